seg_scan_driver: RTL and testbench

Time-multiplexed scan driver that sits directly upstream of the seven-segment decoder. It holds a multi-digit hex value and walks one digit slot at a time. Each slot presents the active nibble on `digit` for the decoder and drives the matching active-low anode. New values are double-buffered and only take effect at a frame boundary, so the display never tears. Leading-zero suppression, per-digit blanking and an anti-ghosting dead time are built in.

---
 rtl/seg_pkg.sv | 12 +
 rtl/seg_lz_mask.sv | 27 ++
 rtl/seg_scan_driver.sv | 106 ++++++++++
 tb/tb_seg_scan_driver.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment scan path.
// No logic; imported by the scan driver and its sub-blocks.
package seg_pkg;
    localparam int NIBBLE_W        = 4;
    localparam int DEF_NUM_DIGITS  = 8;
    localparam int DEF_REFRESH_DIV = 50000;

    // All-ones of width w (w <= 64); used for the dark anode pattern.
    function automatic logic [63:0] an_all_off(input int w);
        return {64{1'b1}} >> (64 - w);
    endfunction
endpackage

// File: rtl/seg_lz_mask.sv
// Leading-zero blank vector: slot i dark when lz_en, i != 0 and nibbles i..top are zero.
// Purely combinational, zero latency; no backpressure.
module seg_lz_mask
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS
) (
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] disp,
    input  logic                           lz_en,
    output logic [NUM_DIGITS-1:0]          blank
);

    // nz[i]: some nibble at or above slot i is non-zero (top-down OR chain).
    logic [NUM_DIGITS:0] nz;

    assign nz[NUM_DIGITS] = 1'b0;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_chain
        assign nz[i] = nz[i+1] | (|disp[NIBBLE_W*i +: NIBBLE_W]);
        if (i == 0) begin : g_lsd
            assign blank[i] = 1'b0;
        end else begin : g_upper
            assign blank[i] = lz_en & ~nz[i];
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan driver: walks digit slots, drives active-low anodes and the active nibble.
// Outputs registered, one cycle behind the slot counters; loads are double-buffered to the frame boundary.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
    parameter int REFRESH_DIV = DEF_REFRESH_DIV,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] data_in,
    input  logic                           load,
    input  logic                           lz_en,
    input  logic [NUM_DIGITS-1:0]          blank_mask,
    output logic [NIBBLE_W-1:0]            digit,
    output logic [NUM_DIGITS-1:0]          an_n,
    output logic                           pending,
    output logic                           frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int DW    = NIBBLE_W * NUM_DIGITS;

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = NUM_DIGITS'(an_all_off(NUM_DIGITS));

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [DW-1:0]         disp;
    logic [DW-1:0]         pend_data;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  slot_end;
    logic                  boundary;
    logic                  dead;
    logic                  dark;
    logic [NUM_DIGITS-1:0] an_next;

    seg_lz_mask #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_lz_mask (
        .disp  (disp),
        .lz_en (lz_en),
        .blank (lz_blank)
    );

    assign slot_end = (cnt == CNT_LAST);
    assign boundary = slot_end && (idx == IDX_LAST);

    // Anti-ghosting window at the head of every slot.
    if (DEAD_CYCLES == 0) begin : g_no_dead
        assign dead = 1'b0;
    end else begin : g_dead
        assign dead = (cnt < CNT_W'(DEAD_CYCLES));
    end

    assign dark = dead | blank_mask[idx] | lz_blank[idx];

    always_comb begin
        an_next = AN_OFF;
        if (!dark) begin
            an_next[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            disp       <= '0;
            pend_data  <= '0;
            pending    <= 1'b0;
            an_n       <= AN_OFF;
            digit      <= '0;
            frame_tick <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // A load landing on the boundary bypasses the buffer and drops any older pending value.
            if (boundary) begin
                if (load) begin
                    disp    <= data_in;
                    pending <= 1'b0;
                end else if (pending) begin
                    disp    <= pend_data;
                    pending <= 1'b0;
                end
            end else if (load) begin
                pend_data <= data_in;
                pending   <= 1'b1;
            end

            an_n       <= an_next;
            digit      <= disp[NIBBLE_W*idx +: NIBBLE_W];
            frame_tick <= boundary;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver against a cycle-count reference model.
module tb_seg_scan_driver;
    localparam int N = 4;
    localparam int R = 4;
    localparam int D = 1;
    localparam int F = N * R;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4*N-1:0] data_in = '0;
    logic          load = 1'b0;
    logic          lz_en = 1'b0;
    logic [N-1:0]  blank_mask = '0;
    logic [3:0]    digit;
    logic [N-1:0]  an_n;
    logic          pending;
    logic          frame_tick;

    int checks = 0;
    int errors = 0;

    // Reference model: t = clock edges since reset released.
    int             t = 0;
    logic [4*N-1:0] m_disp = '0;
    logic [4*N-1:0] m_pdata = '0;
    logic           m_pend = 1'b0;
    logic [N-1:0]   exp_an = '1;
    logic [3:0]     exp_digit = '0;
    logic           exp_tick = 1'b0;

    seg_scan_driver #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .DEAD_CYCLES (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .load       (load),
        .lz_en      (lz_en),
        .blank_mask (blank_mask),
        .digit      (digit),
        .an_n       (an_n),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        int   slot;
        int   c;
        logic lzb;
        logic dark;
        @(posedge clk);
        if (rst) begin
            t = 0; m_disp = '0; m_pdata = '0; m_pend = 1'b0;
            exp_an = '1; exp_digit = '0; exp_tick = 1'b0;
        end else begin
            slot = (t / R) % N;
            c    = t % R;
            lzb  = lz_en && (slot != 0) && ((m_disp >> (4 * slot)) == 0);
            dark = (c < D) || blank_mask[slot] || lzb;
            exp_an = '1;
            if (!dark) exp_an[slot] = 1'b0;
            exp_digit = 4'((m_disp >> (4 * slot)) & 16'hF);
            exp_tick  = (slot == N - 1) && (c == R - 1);
            if (exp_tick) begin
                if (load) begin
                    m_disp = data_in; m_pend = 1'b0;
                end else if (m_pend) begin
                    m_disp = m_pdata; m_pend = 1'b0;
                end
            end else if (load) begin
                m_pdata = data_in; m_pend = 1'b1;
            end
            t++;
        end
        #1;
    endtask

    task automatic goto_phase(input int ph);
        for (int k = 0; k < F && (t % F) != ph; k++) step();
    endtask

    task automatic do_load(input logic [4*N-1:0] v);
        data_in = v; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        logic [N-1:0] seq [8];
        int last_tick;
        seq = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD};
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (an_n !== 4'hF || digit !== 4'h0 || pending !== 1'b0 || frame_tick !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: an_n=%b digit=%h pending=%b tick=%b, required 1111/0/0/0",
                         an_n, digit, pending, frame_tick);
            end
        end
        rst = 1'b0;
        last_tick = -1;
        for (int k = 0; k < 3 * F; k++) begin
            step();
            if (k < 8) begin
                checks++;
                if (an_n !== seq[k]) begin
                    errors++;
                    $display("FAIL run_an_seq[%0d]: an_n=%b required %b", k, an_n, seq[k]);
                end
            end
            checks++;
            if (an_n !== exp_an || frame_tick !== exp_tick) begin
                errors++;
                $display("FAIL run_model k=%0d: an_n=%b tick=%b required %b/%b", k, an_n, frame_tick, exp_an, exp_tick);
            end
            if (frame_tick === 1'b1) begin
                if (last_tick >= 0) begin
                    checks++;
                    if (k - last_tick != F) begin
                        errors++;
                        $display("FAIL tick_period: %0d cycles, required %0d", k - last_tick, F);
                    end
                end
                last_tick = k;
            end
        end
        checks++;
        if (last_tick < 0) begin
            errors++;
            $display("FAIL tick_seen: no frame_tick in %0d cycles, required at least one", 3 * F);
        end
    endtask

    task automatic test_load_apply();
        logic [15:0] v;
        v = 16'hA3C5;
        goto_phase(5);
        do_load(v);
        for (int k = 0; k < F && (t % F) != 0; k++) begin
            checks++;
            if (pending !== 1'b1) begin
                errors++;
                $display("FAIL load_pending: pending=%b required 1 at t=%0d", pending, t);
            end
            step();
        end
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL load_pending_clear: pending=%b required 0", pending);
        end
        for (int k = 0; k < F; k++) begin
            step();
            checks++;
            if (digit !== v[4*(k/R) +: 4] || digit !== exp_digit) begin
                errors++;
                $display("FAIL load_digit slot %0d: digit=%h required %h", k / R, digit, v[4*(k/R) +: 4]);
            end
        end
    endtask

    task automatic test_overwrite();
        goto_phase(2);
        do_load(16'h1111);
        step(); step();
        do_load(16'h2222);
        goto_phase(0);
        for (int k = 0; k < F; k++) begin
            step();
            checks++;
            if (digit !== 4'h2 || digit !== exp_digit) begin
                errors++;
                $display("FAIL overwrite_digit: digit=%h required 2", digit);
            end
        end
        goto_phase(6);
        do_load(16'h4444);
        goto_phase(F - 1);
        do_load(16'h3333);
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL simul_pending: pending=%b required 0", pending);
        end
        for (int k = 0; k < F; k++) begin
            step();
            checks++;
            if (digit !== 4'h3 || pending !== 1'b0) begin
                errors++;
                $display("FAIL simul_digit: digit=%h pending=%b required 3/0", digit, pending);
            end
        end
    endtask

    task automatic test_lz();
        logic [15:0] vals [2];
        vals = '{16'h0040, 16'h0000};
        lz_en = 1'b1;
        for (int v = 0; v < 2; v++) begin
            do_load(vals[v]);
            goto_phase(0);
            for (int k = 0; k < F; k++) begin
                step();
                checks++;
                if (an_n !== exp_an || ((k / R) >= (v == 0 ? 2 : 1) && an_n !== 4'hF)) begin
                    errors++;
                    $display("FAIL lz_an v=%h slot %0d: an_n=%b required %b", vals[v], k / R, an_n, exp_an);
                end
                if (v == 1 && k == 1) begin
                    checks++;
                    if (an_n !== 4'hE || digit !== 4'h0) begin
                        errors++;
                        $display("FAIL lz_zero_slot0: an_n=%b digit=%h required 1110/0", an_n, digit);
                    end
                end
            end
        end
        lz_en = 1'b0;
        for (int k = 0; k < F; k++) begin
            step();
            checks++;
            if (an_n !== exp_an || ((k % R) >= D && an_n === 4'hF)) begin
                errors++;
                $display("FAIL lz_off_an slot %0d: an_n=%b required %b", k / R, an_n, exp_an);
            end
        end
    endtask

    task automatic test_blank_random();
        logic [15:0] msk;
        blank_mask = 4'b0010;
        for (int k = 0; k < F; k++) begin
            step();
            checks++;
            if (an_n !== exp_an || ((k / R) == 1 && an_n !== 4'hF)) begin
                errors++;
                $display("FAIL blank_an slot %0d: an_n=%b required %b", k / R, an_n, exp_an);
            end
        end
        for (int k = 0; k < 400; k++) begin
            lz_en      = 1'($urandom_range(0, 1));
            blank_mask = 4'($urandom);
            msk        = {{4{1'($urandom)}}, {4{1'($urandom)}}, {4{1'($urandom)}}, {4{1'($urandom)}}};
            data_in    = 16'($urandom) & msk;
            load       = ($urandom_range(0, 7) == 0);
            step();
            checks++;
            if ({an_n, digit, pending, frame_tick} !== {exp_an, exp_digit, m_pend, exp_tick}) begin
                errors++;
                $display("FAIL random k=%0d: an_n=%b digit=%h pend=%b tick=%b required %b/%h/%b/%b",
                         k, an_n, digit, pending, frame_tick, exp_an, exp_digit, m_pend, exp_tick);
            end
        end
        load = 1'b0; blank_mask = '0; lz_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] seq [4];
        seq = '{4'hF, 4'hE, 4'hE, 4'hE};
        do_load(16'h9876);
        goto_phase(0);
        for (int k = 0; k < R; k++) step();
        goto_phase(6);
        do_load(16'h5A5A);
        goto_phase(9);
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pending_before: pending=%b required 1", pending);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (pending !== 1'b0 || an_n !== 4'hF || digit !== 4'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: pending=%b an_n=%b digit=%h required 0/1111/0", pending, an_n, digit);
        end
        for (int k = 0; k < F; k++) begin
            step();
            checks++;
            if (digit !== 4'h0 || pending !== 1'b0 || an_n !== exp_an || (k < R && an_n !== seq[k])) begin
                errors++;
                $display("FAIL rstmid_run k=%0d: an_n=%b digit=%h pending=%b required %b/0/0",
                         k, an_n, digit, pending, exp_an);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_apply();
        test_overwrite();
        test_lz();
        test_blank_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
